// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: FSM states, word func3 and requester IDs for mem_port_arbiter.
// Shared by the arbiter RTL and its bench.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_D,
    SERVE_I,
    RESP_D,
    RESP_I
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  localparam logic [2:0] FUNC3_WORD = 3'b010;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and downstream memory signals.
// slave = arbiter view; master = requesters plus backing memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              I_READ;
  logic [ADDR_W-1:0] I_ADDRESS;
  logic [DATA_W-1:0] I_READ_DATA;
  logic              I_BUSYWAIT;

  logic              D_READ;
  logic              D_WRITE;
  logic [ADDR_W-1:0] D_ADDRESS;
  logic [DATA_W-1:0] D_WRITE_DATA;
  logic [2:0]        D_FUNC3;
  logic [DATA_W-1:0] D_READ_DATA;
  logic              D_BUSYWAIT;

  logic              M_READ;
  logic              M_WRITE;
  logic [ADDR_W-1:0] M_ADDRESS;
  logic [DATA_W-1:0] M_WRITE_DATA;
  logic [2:0]        M_FUNC3;
  logic [DATA_W-1:0] M_READ_DATA;
  logic              M_BUSYWAIT;

  modport slave (
    input  I_READ, I_ADDRESS,
    output I_READ_DATA, I_BUSYWAIT,
    input  D_READ, D_WRITE, D_ADDRESS,
    input  D_WRITE_DATA, D_FUNC3,
    output D_READ_DATA, D_BUSYWAIT,
    output M_READ, M_WRITE, M_ADDRESS,
    output M_WRITE_DATA, M_FUNC3,
    input  M_READ_DATA, M_BUSYWAIT
  );

  modport master (
    output I_READ, I_ADDRESS,
    input  I_READ_DATA, I_BUSYWAIT,
    output D_READ, D_WRITE, D_ADDRESS,
    output D_WRITE_DATA, D_FUNC3,
    input  D_READ_DATA, D_BUSYWAIT,
    input  M_READ, M_WRITE, M_ADDRESS,
    input  M_WRITE_DATA, M_FUNC3,
    output M_READ_DATA, M_BUSYWAIT
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF fetch and MEM data.
// Ports: CLK, RESET (async high), bus (slave). Macro MEM_ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  mem_port_arbiter_if.slave bus
);

  state_t            state, state_n;
  logic              m_read, m_read_n;
  logic              m_write, m_write_n;
  logic [ADDR_W-1:0] m_addr, m_addr_n;
  logic [DATA_W-1:0] m_wdata, m_wdata_n;
  logic [2:0]        m_f3, m_f3_n;
  logic [DATA_W-1:0] rsp, rsp_n;

  logic d_req;
  logic i_req;
  logic pick_d;

  assign d_req = bus.D_READ | bus.D_WRITE;
  assign i_req = bus.I_READ;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_id_t last_q, last_n;
  // On contention the side not served last wins.
  assign pick_d = d_req &
    (~i_req | (last_q == REQ_I));
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_n   = state;
    m_read_n  = m_read;
    m_write_n = m_write;
    m_addr_n  = m_addr;
    m_wdata_n = m_wdata;
    m_f3_n    = m_f3;
    rsp_n     = rsp;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_n    = last_q;
`endif
    unique case (state)
      IDLE: begin
        if (pick_d) begin
          // Read+write together is a store.
          m_write_n = bus.D_WRITE;
          m_read_n  = ~bus.D_WRITE;
          m_addr_n  = bus.D_ADDRESS;
          m_wdata_n = bus.D_WRITE_DATA;
          m_f3_n    = bus.D_FUNC3;
          state_n   = SERVE_D;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_n    = REQ_D;
`endif
        end else if (i_req) begin
          m_write_n = 1'b0;
          m_read_n  = 1'b1;
          m_addr_n  = bus.I_ADDRESS;
          m_wdata_n = '0;
          m_f3_n    = FUNC3_WORD;
          state_n   = SERVE_I;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_n    = REQ_I;
`endif
        end
      end
      SERVE_D, SERVE_I: begin
        if (!bus.M_BUSYWAIT) begin
          rsp_n     = m_write ? '0
                              : bus.M_READ_DATA;
          m_read_n  = 1'b0;
          m_write_n = 1'b0;
          state_n   = (state == SERVE_D)
                      ? RESP_D : RESP_I;
        end
      end
      RESP_D, RESP_I: state_n = IDLE;
      default:        state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      m_read  <= 1'b0;
      m_write <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_f3    <= '0;
      rsp     <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q  <= REQ_I;
`endif
    end else begin
      state   <= state_n;
      m_read  <= m_read_n;
      m_write <= m_write_n;
      m_addr  <= m_addr_n;
      m_wdata <= m_wdata_n;
      m_f3    <= m_f3_n;
      rsp     <= rsp_n;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q  <= last_n;
`endif
    end
  end

  // Busywaits are purely combinational so a stall is seen immediately.
  assign bus.I_BUSYWAIT   = i_req & (state != RESP_I);
  assign bus.D_BUSYWAIT   = d_req & (state != RESP_D);
  assign bus.I_READ_DATA  = rsp;
  assign bus.D_READ_DATA  = rsp;
  assign bus.M_READ       = m_read;
  assign bus.M_WRITE      = m_write;
  assign bus.M_ADDRESS    = m_addr;
  assign bus.M_WRITE_DATA = m_wdata;
  assign bus.M_FUNC3      = m_f3;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus, queued expected commands/responses.
// Monitors compare downstream commands and requester responses at negedge.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  f3;
  } cmd_t;

  typedef struct {
    req_id_t     id;
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  cmd_t cq[$];
  rsp_t rq[$];
  cmd_t cur;
  int   total;
  int   bad;
  int   cyc;
  int   mem_wait;
  int   cnt;
  logic [31:0] mem_rdata;
  bit   prev_strobe;
  bit   i_ack;
  bit   d_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (bus.M_READ || bus.M_WRITE) cnt <= cnt + 1;
    else cnt <= 0;

  assign bus.M_BUSYWAIT  = (bus.M_READ || bus.M_WRITE)
                           && (cnt < mem_wait);
  assign bus.M_READ_DATA = mem_rdata;

  task automatic check(input string nm,
                       input logic [79:0] act,
                       input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic got_rsp(input req_id_t id,
                         input logic [31:0] d);
    rsp_t e;
    if (rq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL rsp_unexpected: got id=%0d data=%0h want none",
               id, d);
    end else begin
      e = rq.pop_front();
      check("rsp", {id, d}, {e.id, e.data});
      if (e.cyc >= 0) check("rsp_cycle", cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if ((bus.M_READ || bus.M_WRITE) && !prev_strobe) begin
      if (cq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL cmd_unexpected: got addr=%0h want none",
                 bus.M_ADDRESS);
      end else begin
        cur = cq.pop_front();
        check("cmd", {bus.M_READ, bus.M_WRITE, bus.M_ADDRESS,
                      bus.M_WRITE_DATA, bus.M_FUNC3}, cur);
      end
    end else if (bus.M_READ || bus.M_WRITE) begin
      check("addr_stable", bus.M_ADDRESS, cur.addr);
    end
    prev_strobe = bus.M_READ || bus.M_WRITE;
    if (bus.I_READ && !bus.I_BUSYWAIT) begin
      got_rsp(REQ_I, bus.I_READ_DATA);
      i_ack = 1'b1;
    end
    if ((bus.D_READ || bus.D_WRITE) && !bus.D_BUSYWAIT) begin
      got_rsp(REQ_D, bus.D_READ_DATA);
      d_ack = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (i_ack) begin
      bus.I_READ = 1'b0;
      i_ack = 1'b0;
    end
    if (d_ack) begin
      bus.D_READ  = 1'b0;
      bus.D_WRITE = 1'b0;
      d_ack = 1'b0;
    end
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((bus.I_READ || bus.D_READ || bus.D_WRITE ||
            rq.size() != 0 || cq.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) begin
      total++;
      bad++;
      $display("FAIL wait_quiet: got timeout want idle");
    end
    tick();
    tick();
  endtask

  task automatic push_cmd(input logic rd, input logic wr,
                          input logic [31:0] a,
                          input logic [31:0] wd,
                          input logic [2:0] f3);
    cq.push_back({rd, wr, a, wd, f3});
  endtask

  task automatic push_rsp(input req_id_t id,
                          input logic [31:0] d,
                          input int c);
    rsp_t r;
    r.id = id;
    r.data = d;
    r.cyc = c;
    rq.push_back(r);
  endtask

  task automatic set_d(input logic rd, input logic wr,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [2:0] f3);
    bus.D_READ       = rd;
    bus.D_WRITE      = wr;
    bus.D_ADDRESS    = a;
    bus.D_WRITE_DATA = wd;
    bus.D_FUNC3      = f3;
  endtask

  initial begin
    int c;
    total = 0;
    bad = 0;
    cyc = 0;
    cnt = 0;
    mem_wait = 0;
    mem_rdata = '0;
    prev_strobe = 1'b0;
    i_ack = 1'b0;
    d_ack = 1'b0;
    rst = 1'b1;
    bus.I_READ = 1'b1;
    bus.I_ADDRESS = 32'h0;
    set_d(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);

    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_strobes", {bus.M_READ, bus.M_WRITE}, 2'b00);
    check("rst_addr", bus.M_ADDRESS, 32'h0);
    check("rst_wdata_f3", {bus.M_WRITE_DATA, bus.M_FUNC3}, 35'h0);
    check("rst_rdata", {bus.I_READ_DATA, bus.D_READ_DATA}, 64'h0);
    check("rst_ibusy_follow", bus.I_BUSYWAIT, 1'b1);
    check("rst_dbusy_idle", bus.D_BUSYWAIT, 1'b0);
    bus.I_READ = 1'b0;
    #1;
    check("rst_ibusy_drop", bus.I_BUSYWAIT, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Fetch only, zero wait.
    mem_rdata = 32'h00500093;
    c = cyc;
    bus.I_READ = 1'b1;
    bus.I_ADDRESS = 32'h40;
    #1;
    check("fetch_busy_same_cycle", bus.I_BUSYWAIT, 1'b1);
    push_cmd(1'b1, 1'b0, 32'h40, 32'h0, FUNC3_WORD);
    push_rsp(REQ_I, 32'h00500093, c + 2);
    wait_quiet();

    // Store and fetch together; last grant is fetch either way.
    mem_rdata = 32'h12345678;
    c = cyc;
    bus.I_READ = 1'b1;
    bus.I_ADDRESS = 32'h44;
    set_d(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b000);
    push_cmd(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b000);
    push_rsp(REQ_D, 32'h0, c + 2);
    push_cmd(1'b1, 1'b0, 32'h44, 32'h0, FUNC3_WORD);
    push_rsp(REQ_I, 32'h12345678, c + 5);
    wait_quiet();

    // Load alone, then load and fetch together after a data grant.
    mem_rdata = 32'hCAFEF00D;
    c = cyc;
    set_d(1'b1, 1'b0, 32'h200, 32'h0, 3'b010);
    push_cmd(1'b1, 1'b0, 32'h200, 32'h0, 3'b010);
    push_rsp(REQ_D, 32'hCAFEF00D, c + 2);
    wait_quiet();
    mem_rdata = 32'h0000ABCD;
    c = cyc;
    bus.I_READ = 1'b1;
    bus.I_ADDRESS = 32'h48;
    set_d(1'b1, 1'b0, 32'h204, 32'h0, 3'b100);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    push_cmd(1'b1, 1'b0, 32'h48, 32'h0, FUNC3_WORD);
    push_rsp(REQ_I, 32'h0000ABCD, c + 2);
    push_cmd(1'b1, 1'b0, 32'h204, 32'h0, 3'b100);
    push_rsp(REQ_D, 32'h0000ABCD, c + 5);
`else
    push_cmd(1'b1, 1'b0, 32'h204, 32'h0, 3'b100);
    push_rsp(REQ_D, 32'h0000ABCD, c + 2);
    push_cmd(1'b1, 1'b0, 32'h48, 32'h0, FUNC3_WORD);
    push_rsp(REQ_I, 32'h0000ABCD, c + 5);
`endif
    wait_quiet();

    // Load with four memory wait cycles.
    mem_wait = 4;
    mem_rdata = 32'h0000BEEF;
    c = cyc;
    set_d(1'b1, 1'b0, 32'h300, 32'h0, 3'b001);
    push_cmd(1'b1, 1'b0, 32'h300, 32'h0, 3'b001);
    push_rsp(REQ_D, 32'h0000BEEF, c + 6);
    wait_quiet();
    mem_wait = 0;

    // Read and write together become a store.
    mem_rdata = 32'hFFFFFFFF;
    c = cyc;
    set_d(1'b1, 1'b1, 32'h400, 32'h55AA55AA, 3'b010);
    push_cmd(1'b0, 1'b1, 32'h400, 32'h55AA55AA, 3'b010);
    push_rsp(REQ_D, 32'h0, c + 2);
    wait_quiet();

    // Reset while serving a load, then re-serve.
    mem_wait = 10;
    mem_rdata = 32'h0BADF00D;
    set_d(1'b1, 1'b0, 32'h500, 32'h0, 3'b010);
    push_cmd(1'b1, 1'b0, 32'h500, 32'h0, 3'b010);
    tick();
    tick();
    check("serve_strobe_up", bus.M_READ, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_async_strobe", bus.M_READ, 1'b0);
    check("rst_dbusy_held", bus.D_BUSYWAIT, 1'b1);
    tick();
    rst = 1'b0;
    mem_wait = 0;
    c = cyc;
    push_cmd(1'b1, 1'b0, 32'h500, 32'h0, 3'b010);
    push_rsp(REQ_D, 32'h0BADF00D, c + 2);
    wait_quiet();

    // Fetch withdrawn mid-serve.
    mem_wait = 2;
    bus.I_READ = 1'b1;
    bus.I_ADDRESS = 32'h600;
    push_cmd(1'b1, 1'b0, 32'h600, 32'h0, FUNC3_WORD);
    tick();
    bus.I_READ = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("withdraw_idle",
          {bus.M_READ, bus.M_WRITE}, 2'b00);
    check("queues_empty", cq.size() + rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
